// File: rtl/cpu_ctrl_fsm.sv
// Instruction sequencer for the simple RISC CPU: Moore FSM driving datapath, regfile, PC and memory strobes.
// Latency: strobes are registered alongside the state, so they always reflect the current state; 4-10 cycles per instruction.
// Backpressure: none; the sequencer advances every cycle, and memory is assumed to answer within the fixed READ/WRITE slots.
// Optional HALT instruction (111/00) is enabled by defining CPU_CTRL_HALT_EN.
module cpu_ctrl_fsm #(
    parameter int STATE_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         opcode,
    input  logic [1:0]         op,
    output logic               load_ir,
    output logic               load_pc,
    output logic               reset_pc,
    output logic               addr_sel,
    output logic               load_addr,
    output logic [1:0]         mem_cmd,
    output logic [2:0]         nsel,
    output logic [1:0]         vsel,
    output logic               write,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               asel,
    output logic               bsel,
    output logic               halted,
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [STATE_W-1:0] {
        RST, IF1, IF2, UPC, DEC, WIMM, GETA, GETB, SHFT, ALU,
        WRD, ADDR, LADR, MRD, WMEM, GETD, SHD, MWR
`ifdef CPU_CTRL_HALT_EN
        , HALT
`endif
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_LDR = 3'b011;
    localparam logic [2:0] OPC_STR = 3'b100;
`ifdef CPU_CTRL_HALT_EN
    localparam logic [2:0] OPC_HLT = 3'b111;
`endif
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] SEL_RN = 3'b001;
    localparam logic [2:0] SEL_RD = 3'b010;
    localparam logic [2:0] SEL_RM = 3'b100;

    localparam logic [1:0] WB_C     = 2'b00;
    localparam logic [1:0] WB_IMM8  = 2'b10;
    localparam logic [1:0] WB_MDATA = 2'b11;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       halted;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;

    function automatic state_t next_state(input state_t st, input logic [2:0] oc, input logic [1:0] o);
        state_t nxt;
        nxt = RST;
        case (st)
            RST:  nxt = IF1;
            IF1:  nxt = IF2;
            IF2:  nxt = UPC;
            UPC:  nxt = DEC;
            DEC: begin
                // Unrecognised encodings retire as a NOP straight back to fetch.
                nxt = IF1;
                if (oc == OPC_MOV && o == OP_MOV_IMM)
                    nxt = WIMM;
                else if (oc == OPC_MOV && o == 2'b00)
                    nxt = GETB;
                else if (oc == OPC_ALU)
                    nxt = GETA;
                else if ((oc == OPC_LDR || oc == OPC_STR) && o == 2'b00)
                    nxt = GETA;
`ifdef CPU_CTRL_HALT_EN
                else if (oc == OPC_HLT && o == 2'b00)
                    nxt = HALT;
`endif
            end
            WIMM: nxt = IF1;
            GETA: nxt = (oc == OPC_ALU) ? GETB : ADDR;
            GETB: nxt = (oc == OPC_MOV) ? SHFT : ALU;
            SHFT: nxt = WRD;
            ALU:  nxt = (o == OP_CMP) ? IF1 : WRD;
            WRD:  nxt = IF1;
            ADDR: nxt = LADR;
            LADR: nxt = (oc == OPC_LDR) ? MRD : GETD;
            MRD:  nxt = WMEM;
            WMEM: nxt = IF1;
            GETD: nxt = SHD;
            SHD:  nxt = MWR;
            MWR:  nxt = IF1;
`ifdef CPU_CTRL_HALT_EN
            HALT: nxt = HALT;
`endif
            default: nxt = RST;
        endcase
        return nxt;
    endfunction

    function automatic ctrl_t decode(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            RST: begin
                c.reset_pc = 1'b1;
                c.load_pc  = 1'b1;
            end
            IF1: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
            end
            IF2: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
                c.load_ir  = 1'b1;
            end
            UPC:  c.load_pc = 1'b1;
            WIMM: begin
                c.nsel  = SEL_RN;
                c.vsel  = WB_IMM8;
                c.write = 1'b1;
            end
            GETA: begin
                c.nsel  = SEL_RN;
                c.loada = 1'b1;
            end
            GETB: begin
                c.nsel  = SEL_RM;
                c.loadb = 1'b1;
            end
            SHFT, SHD: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            ALU: begin
                c.loadc = 1'b1;
                c.loads = (op == OP_CMP);
            end
            WRD: begin
                c.nsel  = SEL_RD;
                c.vsel  = WB_C;
                c.write = 1'b1;
            end
            ADDR: begin
                c.bsel  = 1'b1;
                c.loadc = 1'b1;
            end
            LADR: c.load_addr = 1'b1;
            MRD:  c.mem_cmd = MEM_READ;
            WMEM: begin
                c.mem_cmd = MEM_READ;
                c.nsel    = SEL_RD;
                c.vsel    = WB_MDATA;
                c.write   = 1'b1;
            end
            GETD: begin
                c.nsel  = SEL_RD;
                c.loadb = 1'b1;
            end
            MWR:  c.mem_cmd = MEM_WRITE;
`ifdef CPU_CTRL_HALT_EN
            HALT: c.halted = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    assign state_nxt = next_state(state, opcode, op);

    // Strobes are decoded from the state being entered, so registered outputs still track the current state.
    // ALU's loads bit depends on op, which is stable from DEC onward because IR only loads in IF2.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST;
            ctrl  <= decode(RST);
        end else begin
            state <= state_nxt;
            ctrl  <= decode(state_nxt);
        end
    end

    assign load_ir   = ctrl.load_ir;
    assign load_pc   = ctrl.load_pc;
    assign reset_pc  = ctrl.reset_pc;
    assign addr_sel  = ctrl.addr_sel;
    assign load_addr = ctrl.load_addr;
    assign mem_cmd   = ctrl.mem_cmd;
    assign nsel      = ctrl.nsel;
    assign vsel      = ctrl.vsel;
    assign write     = ctrl.write;
    assign loada     = ctrl.loada;
    assign loadb     = ctrl.loadb;
    assign loadc     = ctrl.loadc;
    assign loads     = ctrl.loads;
    assign asel      = ctrl.asel;
    assign bsel      = ctrl.bsel;
    assign halted    = ctrl.halted;
    assign state_dbg = state;

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Instruction-sequencing controller for the simple RISC CPU.
- Decodes the IR fields and drives every datapath, register-file, PC and memory control strobe through a Moore state machine.
- One instruction executes per pass: fetch, PC update, decode, execute, writeback.
- Sits between the instruction register/decoder and the datapath plus memory interface inside cpu.

Parameters:
STATE_W, 5, width of state register and state_dbg port (must hold all 19 states)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset; forces state RST on the next edge
opcode  input  3  IR[15:13]
op  input  2  IR[12:11]
load_ir  output  1  capture mdata into IR
load_pc  output  1  PC register enable
reset_pc  output  1  PC mux select: 1 = load 0, 0 = PC+1
addr_sel  output  1  memory address mux: 1 = PC, 0 = data_address register
load_addr  output  1  data_address register enable (takes datapath out[8:0])
mem_cmd  output  2  00 NONE, 01 READ, 10 WRITE
nsel  output  3  register select, one-hot: 001 Rn, 010 Rd, 100 Rm, 000 none
vsel  output  2  writeback mux: 00 C, 01 PC, 10 sximm8, 11 mdata
write  output  1  register-file write enable
loada  output  1  A register enable
loadb  output  1  B register enable
loadc  output  1  C register enable
loads  output  1  status register (N, V, Z) enable
asel  output  1  1 = A operand forced to 0
bsel  output  1  1 = B operand is sximm5
halted  output  1  high while in HALT
state_dbg  output  STATE_W  current state encoding, for bench only

Behaviour:
- All outputs are decoded combinationally from the current state only (Moore). Any strobe not listed for a state is 0; nsel defaults to 000 and vsel to 00.
- Reset: reset sampled high at a clk edge puts the state in RST; holding reset keeps it there.
- RST outputs: reset_pc=1, load_pc=1, all others 0.
- Reset mid-instruction abandons that instruction; no write or store strobe is issued after the edge that samples reset.
- States, their outputs, and next state:
  - RST: next IF1.
  - IF1: addr_sel=1, mem_cmd=READ. Next IF2.
  - IF2: addr_sel=1, mem_cmd=READ, load_ir=1. Next UPC.
  - UPC: load_pc=1, reset_pc=0. Next DEC.
  - DEC: no strobes; branches on {opcode, op}:
    - 110/10 (MOV imm) to WIMM.
    - 110/00 (MOV reg) to GETB.
    - 101/xx (ALU) to GETA.
    - 011/00 (LDR) to GETA.
    - 100/00 (STR) to GETA.
    - 111/00 (HALT) as defined under Optional Feature.
    - Any other encoding to IF1 (executes as NOP).
  - WIMM: nsel=Rn, vsel=10, write=1. Next IF1.
  - GETA: nsel=Rn, loada=1. Next GETB for ALU; ADDR for LDR and STR.
  - GETB: nsel=Rm, loadb=1. Next SHFT for MOV reg; ALU for ALU ops.
  - SHFT: asel=1, loadc=1. Next WRD.
  - ALU: loadc=1, plus loads=1 when op=01 (CMP). Next IF1 if CMP, else WRD.
  - WRD: nsel=Rd, vsel=00, write=1. Next IF1.
  - ADDR: bsel=1, loadc=1. Next LADR.
  - LADR: load_addr=1. Next MRD for LDR; GETD for STR.
  - MRD: addr_sel=0, mem_cmd=READ. Next WMEM.
  - WMEM: addr_sel=0, mem_cmd=READ, nsel=Rd, vsel=11, write=1. Next IF1.
  - GETD: nsel=Rd, loadb=1. Next SHD.
  - SHD: asel=1, loadc=1. Next MWR.
  - MWR: addr_sel=0, mem_cmd=WRITE. Next IF1.
- Latency from IF1 to next IF1, in cycles:
  - MOV imm: 5
  - CMP: 7
  - MOV reg: 7
  - ADD/AND/MVN: 8
  - LDR: 9
  - STR: 10
  - illegal: 4
- Opcode and op are sampled only in DEC, GETA, GETB, ALU and LADR; IR is stable there because load_ir is asserted only in IF2.
- Exactly one of mem_cmd READ/WRITE, or neither, in any cycle; write and mem_cmd=WRITE are never both high.

Optional Feature:
- Macro: CPU_CTRL_HALT_EN.
- Defined:
  - DEC with 111/00 goes to HALT.
  - HALT: halted=1, all other strobes 0, load_pc=0.
  - HALT self-loops until reset; only reset exits.
- Undefined:
  - 111/00 is illegal and goes DEC to IF1 (NOP).
  - HALT state is absent and halted is tied 0.

Test Plan:
- Reset then MOV imm: reset high 2 cycles, then low, with IR=16'b110_10_000_00000111.
  - State sequence RST, IF1, IF2, UPC, DEC, WIMM, IF1.
  - WIMM shows nsel=001, vsel=10, write=1; RST shows reset_pc=1, load_pc=1.
- ADD vs CMP: IR=101_00 (ADD) gives GETA, GETB, ALU, WRD with loads=0 in ALU.
  - IR=101_01 (CMP) gives ALU with loads=1, then IF1 directly.
  - write never asserted for CMP.
- LDR then STR, each checked to IF1:
  - LDR: exactly one load_addr pulse, and WMEM with vsel=11, mem_cmd=01.
  - STR: GETD with nsel=010, and a single MWR cycle with mem_cmd=10, addr_sel=0.
- Illegal and HALT:
  - IR=16'hE000 with CPU_CTRL_HALT_EN defined: halted=1 for 20 cycles, load_pc=0, then reset returns to RST.
  - Same IR without the macro: DEC to IF1, halted=0.
  - IR=16'h0000 either build: DEC to IF1.
- Reset mid-STR: assert reset while in GETD.
  - Next state is RST and no MWR/WRITE cycle occurs.
  - After release, fetch restarts with PC=0 (reset_pc and load_pc high in RST).
